// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester front end for a shared combinational ALU.
//                IDLE grants one requester and latches its operation, EXEC
//                drives the ALU for one cycle and captures its result, and
//                RESP holds the response until the consumer accepts it.
//  Config      : `define ALU_ARB_RR_EN -> round-robin arbitration on ties;
//                undefined (default) -> fixed priority, req0 wins ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  // shared ALU
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  // response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_sel_q, op_sel_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;

  // Raw grant decision; only acted upon while the FSM sits in IDLE.
  logic                gnt0_w, gnt1_w;

`ifdef ALU_ARB_RR_EN
  // Pointer remembers the id granted last; on a tie the other id wins.
  logic                rr_ptr_q, rr_ptr_d;

  // Round-robin tie break, plain pass-through when only one is valid.
  always_comb begin
    gnt0_w = req0_valid;
    gnt1_w = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt0_w = rr_ptr_q;
      gnt1_w = ~rr_ptr_q;
    end
  end

  // Pointer follows every grant issued from IDLE.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && (gnt0_w || gnt1_w)) begin
      rr_ptr_d = gnt1_w;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: req0 always wins a tie.
  always_comb begin
    gnt0_w = req0_valid;
    gnt1_w = req1_valid & ~req0_valid;
  end
`endif

  // FSM next state, handshakes, ALU drive and register next values.
  always_comb begin
    state_d    = state_q;
    op_sel_d   = op_sel_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    result_d   = result_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_sel    = 4'd0;
    alu_a      = '0;
    alu_b      = '0;
    rsp_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt0_w) begin
          req0_ready = 1'b1;
          op_sel_d   = req0_sel;
          op_a_d     = req0_a;
          op_b_d     = req0_b;
          id_d       = ID_W'(0);
          state_d    = S_EXEC;
        end else if (gnt1_w) begin
          req1_ready = 1'b1;
          op_sel_d   = req1_sel;
          op_a_d     = req1_a;
          op_b_d     = req1_b;
          id_d       = ID_W'(1);
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // Select code goes to the ALU untouched, undefined codes included.
        alu_sel  = op_sel_q;
        alu_a    = op_a_q;
        alu_b    = op_b_q;
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_sel_q <= 4'd0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_sel, req1_sel, alu_sel;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic          alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]    rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .ID_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  // Behavioural shared ALU: add, sub, and; anything else returns a ^ b.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0101: alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          v0;
    logic          v1;
    logic [3:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_res;
    logic          exp_zero;
    logic          exp_id;
    int            hold;
  } vec_t;

  vec_t vecs[6];

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = 4'd0; req0_a = '0; req0_b = '0;
    req1_sel = 4'd0; req1_a = '0; req1_b = '0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ready0"}, req0_ready, 0);
    chk({nm, "_ready1"}, req1_ready, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_result"}, rsp_result, 0);
    chk({nm, "_rsp_zero"}, rsp_zero, 0);
    chk({nm, "_alu_sel"}, alu_sel, 0);
    chk({nm, "_alu_ab"}, {alu_a, alu_b}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One single-requester transaction starting from IDLE at a falling edge.
  task automatic do_op(input vec_t v, input string nm);
    @(negedge clk);
    req0_valid = v.v0;
    req1_valid = v.v1;
    req0_sel   = v.v0 ? v.sel : ~v.sel;
    req0_a     = v.v0 ? v.a   : ~v.a;
    req0_b     = v.v0 ? v.b   : ~v.b;
    req1_sel   = v.v1 ? v.sel : ~v.sel;
    req1_a     = v.v1 ? v.a   : ~v.a;
    req1_b     = v.v1 ? v.b   : ~v.b;
    rsp_ready  = (v.hold == 0);
    #1;
    chk({nm, "_grant_ready0"}, req0_ready, (v.exp_id == 1'b0));
    chk({nm, "_grant_ready1"}, req1_ready, (v.exp_id == 1'b1));
    chk({nm, "_idle_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_idle_alu_sel"}, alu_sel, 0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({nm, "_exec_alu_sel"}, alu_sel, v.sel);
    chk({nm, "_exec_alu_a"}, alu_a, v.a);
    chk({nm, "_exec_alu_b"}, alu_b, v.b);
    chk({nm, "_exec_ready"}, {req0_ready, req1_ready}, 0);
    chk({nm, "_exec_rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    #1;
    chk({nm, "_resp_valid"}, rsp_valid, 1);
    chk({nm, "_resp_id"}, rsp_id, v.exp_id);
    chk({nm, "_resp_result"}, rsp_result, v.exp_res);
    chk({nm, "_resp_zero"}, rsp_zero, v.exp_zero);
    chk({nm, "_resp_alu_idle"}, {alu_sel, alu_a, alu_b}, 0);
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      #1;
      chk({nm, "_hold_valid"}, rsp_valid, 1);
      chk({nm, "_hold_stable"}, {rsp_id, rsp_zero, rsp_result},
          {v.exp_id, v.exp_zero, v.exp_res});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk({nm, "_back_idle"}, rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic exp_order[4];
    logic seen;

    // sel, a, b, result, zero, id, hold
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 4'b0001, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 4};
    vecs[2] = '{1'b1, 1'b0, 4'b0101, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1};
    vecs[4] = '{1'b1, 1'b0, 4'b1100, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b1, 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1, 2};

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table-driven single-requester transactions.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulsed while a req0 op is in EXEC: that op must vanish.
    @(negedge clk);
    req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd40; req0_b = 32'd2;
    rsp_ready = 1'b1;
    #1;
    chk("rst_exec_grant", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("rst_exec_in_exec", alu_a, 32'd40);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    chk("rst_exec_no_rsp", seen, 0);
    rsp_ready = 1'b0;
    do_op(vecs[0], "post_rst");

    // Both requesters valid continuously for four operations.
`ifdef ALU_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    req0_valid = 1'b1; req0_sel = 4'b0000; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_sel = 4'b0000; req1_a = 32'd10; req1_b = 32'd20;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie%0d_ready0", i), req0_ready, !exp_order[i]);
      chk($sformatf("tie%0d_ready1", i), req1_ready, exp_order[i]);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("tie%0d_rsp_id", i), rsp_id, exp_order[i]);
      chk($sformatf("tie%0d_result", i), rsp_result, exp_order[i] ? 32'd30 : 32'd3);
      @(negedge clk);
    end
    idle_inputs();
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
